// File: rtl/mac_accumulate.sv
// Frame-based multiply-accumulate front end for an external combinational 8x8 multiplier.
// Sums N_TERMS products per frame and presents the result on a valid/ready port.
module mac_accumulate #(
    parameter int unsigned N_TERMS = 8,
    parameter int unsigned ACC_W   = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic [7:0]       mul_a,
    output logic [7:0]       mul_b,
    input  logic [15:0]      mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    localparam int unsigned CNT_W = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    typedef enum logic [1:0] {
        StAcc,
        StLast,
        StOut
    } state_e;

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic             ovf_acc;
    logic             p_valid;
    logic             accept;
    logic [ACC_W:0]   sum_ext;

    assign in_ready = (state == StAcc);
    assign accept   = in_valid & in_ready;

    // Extra top bit of sum_ext is the carry out of the accumulator.
    assign sum_ext = {1'b0, acc} + (ACC_W + 1)'(mul_p);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StAcc;
            cnt       <= '0;
            acc       <= '0;
            ovf_acc   <= 1'b0;
            p_valid   <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            p_valid <= accept;
            if (accept) begin
                mul_a <= in_a;
                mul_b <= in_b;
            end

            unique case (state)
                StAcc: begin
                    if (p_valid) begin
                        acc     <= sum_ext[ACC_W-1:0];
                        ovf_acc <= ovf_acc | sum_ext[ACC_W];
                    end
                    if (accept) begin
                        if (cnt == LAST_CNT) begin
                            cnt   <= '0;
                            state <= StLast;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                StLast: begin
                    // Final product bypasses acc straight into the result register.
                    out_sum   <= sum_ext[ACC_W-1:0];
                    out_ovf   <= ovf_acc | sum_ext[ACC_W];
                    out_valid <= 1'b1;
                    acc       <= '0;
                    ovf_acc   <= 1'b0;
                    state     <= StOut;
                end
                StOut: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= StAcc;
                    end
                end
                default: state <= StAcc;
            endcase
        end
    end

endmodule
